// File: rtl/controle_mux_pkg.sv
// Shared definitions for controle_mux: FSM states, command priority and {ch1,ch0} select codes.
package controle_mux_pkg;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        CARGA   = 2'd1,
        DESL_ED = 2'd2,
        DESL_DE = 2'd3
    } estado_t;

    typedef enum logic [2:0] {
        CMD_NENHUM   = 3'd0,
        CMD_PARAR    = 3'd1,
        CMD_CARREGAR = 3'd2,
        CMD_ESQ_DIR  = 3'd3,
        CMD_DIR_ESQ  = 3'd4
    } comando_t;

    localparam logic [1:0] SEL_OCIOSO  = 2'b11;
    localparam logic [1:0] SEL_CARGA   = 2'b00;
    localparam logic [1:0] SEL_DESL_ED = 2'b01;
    localparam logic [1:0] SEL_DESL_DE = 2'b10;

    // Only the highest-priority asserted command survives; the rest are dropped.
    function automatic comando_t prioriza(input logic parar, input logic carregar,
                                          input logic esq_dir, input logic dir_esq);
        comando_t cmd;
        if (parar)         cmd = CMD_PARAR;
        else if (carregar) cmd = CMD_CARREGAR;
        else if (esq_dir)  cmd = CMD_ESQ_DIR;
        else if (dir_esq)  cmd = CMD_DIR_ESQ;
        else               cmd = CMD_NENHUM;
        return cmd;
    endfunction

    function automatic logic [1:0] seleciona(input estado_t estado);
        logic [1:0] sel;
        case (estado)
            OCIOSO:  sel = SEL_OCIOSO;
            CARGA:   sel = SEL_CARGA;
            DESL_ED: sel = SEL_DESL_ED;
            DESL_DE: sel = SEL_DESL_DE;
            default: sel = SEL_OCIOSO;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/controle_mux_divisor_tick.sv
// Prescaler: counts 0..PRESCALE-1 while clear is low; tick marks the last count of each period.
module divisor_tick #(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] ULTIMO = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] UM     = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins, otherwise wrap at the end of the period.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (cnt_q == ULTIMO) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + UM;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == ULTIMO);

endmodule

// File: rtl/controle_mux.sv
// Mux-select / shift-register controller. Define CONTROLE_MUX_VAI_VEM_EN to make
// completed sequences bounce to the opposite direction forever instead of stopping.
module controle_mux
    import controle_mux_pkg::*;
#(
    parameter int PRESCALE = 4,
    parameter int N_PASSOS = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              carregar,
    input  logic                              iniciar_esq_dir,
    input  logic                              iniciar_dir_esq,
    input  logic                              parar,
    output logic                              ch0,
    output logic                              ch1,
    output logic                              reg_en,
    output logic                              ocupado,
    output logic [$clog2(N_PASSOS+1)-1:0]     passo,
    output logic                              fim
);

    localparam int PW = $clog2(N_PASSOS + 1);
    localparam logic [PW-1:0] ULTIMO_PASSO = PW'(N_PASSOS - 1);
    localparam logic [PW-1:0] TOTAL_PASSOS = PW'(N_PASSOS);
    localparam logic [PW-1:0] UM           = PW'(1);

    estado_t       state_q, state_d;
    logic [PW-1:0] passo_q, passo_d;
    logic          fim_q, fim_d;
    logic          reg_en_s;
    logic          tick_s;
    logic          clear_s;
    comando_t      cmd_s;
    estado_t       espelho_s;
    comando_t      cmd_oposto_s;

    // The prescaler only runs while the FSM stays in the same shift state.
    assign clear_s = !(((state_q == DESL_ED) || (state_q == DESL_DE)) && (state_d == state_q));

    divisor_tick #(
        .PRESCALE (PRESCALE)
    ) u_divisor_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear_s),
        .tick  (tick_s)
    );

    // Next-state, step counter and load-enable decode.
    always_comb begin
        state_d      = state_q;
        passo_d      = passo_q;
        fim_d        = 1'b0;
        reg_en_s     = 1'b0;
        cmd_s        = prioriza(parar, carregar, iniciar_esq_dir, iniciar_dir_esq);
        espelho_s    = (state_q == DESL_ED) ? DESL_DE : DESL_ED;
        cmd_oposto_s = (state_q == DESL_ED) ? CMD_DIR_ESQ : CMD_ESQ_DIR;
        case (state_q)
            OCIOSO: begin
                case (cmd_s)
                    CMD_CARREGAR: state_d = CARGA;
                    CMD_ESQ_DIR: begin
                        state_d = DESL_ED;
                        passo_d = '0;
                    end
                    CMD_DIR_ESQ: begin
                        state_d = DESL_DE;
                        passo_d = '0;
                    end
                    default: state_d = OCIOSO;
                endcase
            end
            CARGA: begin
                state_d  = OCIOSO;
                reg_en_s = (cmd_s != CMD_PARAR);
            end
            DESL_ED, DESL_DE: begin
                reg_en_s = tick_s && (cmd_s != CMD_PARAR);
                if (cmd_s == CMD_PARAR) begin
                    state_d = OCIOSO;
                end else if (cmd_s == cmd_oposto_s) begin
                    state_d = espelho_s;
                    passo_d = '0;
                end else if (reg_en_s) begin
                    if (passo_q == ULTIMO_PASSO) begin
                        fim_d = 1'b1;
`ifdef CONTROLE_MUX_VAI_VEM_EN
                        state_d = espelho_s;
                        passo_d = '0;
`else
                        state_d = OCIOSO;
                        passo_d = TOTAL_PASSOS;
`endif
                    end else begin
                        passo_d = passo_q + UM;
                    end
                end else begin
                    passo_d = passo_q;
                end
            end
            default: state_d = OCIOSO;
        endcase
    end

    // State, step count and completion flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= OCIOSO;
            passo_q <= '0;
            fim_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            passo_q <= passo_d;
            fim_q   <= fim_d;
        end
    end

    assign {ch1, ch0} = seleciona(state_q);
    assign reg_en     = reg_en_s;
    assign ocupado    = (state_q != OCIOSO);
    assign passo      = passo_q;
    assign fim        = fim_q;

endmodule

// File: tb/tb_controle_mux.sv
// Randomized and directed bench for controle_mux (PRESCALE=4, N_PASSOS=3) against a cycle-level reference model.
module tb_controle_mux;

    localparam int PRESC = 4;
    localparam int NP    = 3;

    logic       clk;
    logic       rst_n;
    logic       carregar, iniciar_esq_dir, iniciar_dir_esq, parar;
    logic       ch0, ch1, reg_en, ocupado, fim;
    logic [1:0] passo;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: mode 0 idle, 1 load, 2 left-to-right, 3 right-to-left.
    int m_modo, m_ciclos, m_passo;
    bit m_fim;

    controle_mux #(.PRESCALE(PRESC), .N_PASSOS(NP)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .carregar        (carregar),
        .iniciar_esq_dir (iniciar_esq_dir),
        .iniciar_dir_esq (iniciar_dir_esq),
        .parar           (parar),
        .ch0             (ch0),
        .ch1             (ch1),
        .reg_en          (reg_en),
        .ocupado         (ocupado),
        .passo           (passo),
        .fim             (fim)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [6:0] obs();
        return {ch1, ch0, reg_en, ocupado, passo, fim};
    endfunction

    function automatic logic [6:0] esperado();
        logic [1:0] sel;
        logic       re;
        case (m_modo)
            0:       sel = 2'b11;
            1:       sel = 2'b00;
            2:       sel = 2'b01;
            default: sel = 2'b10;
        endcase
        if (m_modo == 1)      re = !parar;
        else if (m_modo >= 2) re = ((m_ciclos % PRESC) == PRESC - 1) && !parar;
        else                  re = 1'b0;
        return {sel, re, (m_modo != 0), 2'(m_passo), m_fim};
    endfunction

    task automatic modelo_reset();
        m_modo = 0; m_ciclos = 0; m_passo = 0; m_fim = 1'b0;
    endtask

    task automatic modelo_borda();
        int  cmd;
        bit  re;
        if (parar)                cmd = 1;
        else if (carregar)        cmd = 2;
        else if (iniciar_esq_dir) cmd = 3;
        else if (iniciar_dir_esq) cmd = 4;
        else                      cmd = 0;
        re    = ((m_ciclos % PRESC) == PRESC - 1) && !parar;
        m_fim = 1'b0;
        if (m_modo == 0) begin
            if (cmd == 2) m_modo = 1;
            else if (cmd == 3 || cmd == 4) begin
                m_modo = cmd - 1; m_ciclos = 0; m_passo = 0;
            end
        end else if (m_modo == 1) begin
            m_modo = 0;
        end else if (cmd == 1) begin
            m_modo = 0;
        end else if ((cmd == 3 && m_modo == 3) || (cmd == 4 && m_modo == 2)) begin
            m_modo = 5 - m_modo; m_ciclos = 0; m_passo = 0;
        end else begin
            m_ciclos++;
            if (re) begin
                m_passo++;
                if (m_passo == NP) begin
                    m_fim = 1'b1;
`ifdef CONTROLE_MUX_VAI_VEM_EN
                    m_modo = 5 - m_modo; m_ciclos = 0; m_passo = 0;
`else
                    m_modo = 0;
`endif
                end
            end
        end
    endtask

    task automatic aplica(input logic c, input logic ed, input logic de, input logic p);
        carregar = c; iniciar_esq_dir = ed; iniciar_dir_esq = de; parar = p;
        #1;
    endtask

    task automatic avanca();
        @(posedge clk);
        modelo_borda();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        n_cmp++;
        if (obs() !== 7'b11_0_0_00_0) begin
            n_err++;
            $display("FAIL reset: got %b, need %b", obs(), 7'b11_0_0_00_0);
        end
    endtask

    task automatic test_carga();
        aplica(1'b1, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (obs() !== esperado()) begin n_err++; $display("FAIL carga_pedido: got %b, need %b", obs(), esperado()); end
        avanca();
        aplica(1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if ({ch1, ch0, reg_en, fim} !== 4'b0010) begin
            n_err++; $display("FAIL carga_pulso: got %b, need %b", {ch1, ch0, reg_en, fim}, 4'b0010);
        end
        avanca();
        n_cmp++;
        if ({ch1, ch0, reg_en, fim} !== 4'b1100) begin
            n_err++; $display("FAIL carga_volta: got %b, need %b", {ch1, ch0, reg_en, fim}, 4'b1100);
        end
    endtask

    task automatic test_esq_dir();
        aplica(1'b0, 1'b1, 1'b0, 1'b0);
        avanca();
        for (int k = 0; k <= 12; k++) begin
            aplica(1'b0, 1'b0, 1'b0, 1'b0);
            n_cmp++;
            if (obs() !== esperado()) begin n_err++; $display("FAIL esq_dir k=%0d: got %b, need %b", k, obs(), esperado()); end
            if (k == 3 || k == 7 || k == 11) begin
                n_cmp++;
                if ({ch1, ch0, reg_en} !== 3'b011) begin
                    n_err++; $display("FAIL esq_dir_pulso k=%0d: got %b, need %b", k, {ch1, ch0, reg_en}, 3'b011);
                end
            end
            if (k == 12) begin
                n_cmp++;
`ifdef CONTROLE_MUX_VAI_VEM_EN
                if ({ch1, ch0, ocupado, passo, fim} !== 6'b10_1_00_1) begin
                    n_err++; $display("FAIL esq_dir_fim: got %b, need %b", {ch1, ch0, ocupado, passo, fim}, 6'b10_1_00_1);
                end
`else
                if ({ch1, ch0, ocupado, passo, fim} !== 6'b11_0_11_1) begin
                    n_err++; $display("FAIL esq_dir_fim: got %b, need %b", {ch1, ch0, ocupado, passo, fim}, 6'b11_0_11_1);
                end
`endif
            end
            avanca();
        end
        aplica(1'b0, 1'b0, 1'b0, 1'b1);
        avanca();
    endtask

    task automatic test_aborto();
        aplica(1'b0, 1'b0, 1'b1, 1'b0);
        avanca();
        for (int k = 0; k < 4; k++) begin
            aplica(1'b0, 1'b0, 1'b0, 1'b0);
            n_cmp++;
            if (obs() !== esperado()) begin n_err++; $display("FAIL aborto k=%0d: got %b, need %b", k, obs(), esperado()); end
            avanca();
        end
        aplica(1'b0, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if ({ch1, ch0, reg_en} !== 3'b100) begin
            n_err++; $display("FAIL aborto_parar: got %b, need %b", {ch1, ch0, reg_en}, 3'b100);
        end
        avanca();
        for (int k = 0; k < 3; k++) begin
            aplica(1'b0, 1'b0, 1'b0, 1'b0);
            n_cmp++;
            if ({ch1, ch0, ocupado, passo, fim} !== 6'b11_0_01_0) begin
                n_err++; $display("FAIL aborto_ocioso k=%0d: got %b, need %b", k, {ch1, ch0, ocupado, passo, fim}, 6'b11_0_01_0);
            end
            avanca();
        end
    endtask

    task automatic test_troca();
        aplica(1'b0, 1'b1, 1'b0, 1'b0);
        avanca();
        for (int k = 0; k < 4; k++) begin
            aplica(1'b0, 1'b0, 1'b0, 1'b0);
            avanca();
        end
        aplica(1'b0, 1'b0, 1'b1, 1'b0);
        n_cmp++;
        if ({ch1, ch0, passo} !== 4'b01_01) begin
            n_err++; $display("FAIL troca_antes: got %b, need %b", {ch1, ch0, passo}, 4'b01_01);
        end
        avanca();
        for (int k = 0; k < 4; k++) begin
            aplica(1'b0, 1'b0, 1'b0, 1'b0);
            n_cmp++;
            if ({ch1, ch0, passo, reg_en} !== {4'b10_00, (k == 3)}) begin
                n_err++; $display("FAIL troca k=%0d: got %b, need %b", k, {ch1, ch0, passo, reg_en}, {4'b10_00, (k == 3)});
            end
            avanca();
        end
        aplica(1'b0, 1'b0, 1'b0, 1'b1);
        avanca();
    endtask

    task automatic test_reset_meio();
        aplica(1'b0, 1'b1, 1'b0, 1'b0);
        avanca();
        for (int k = 0; k < 7; k++) begin
            aplica(1'b0, 1'b0, 1'b0, 1'b0);
            avanca();
        end
        rst_n = 1'b0;
        #1;
        modelo_reset();
        n_cmp++;
        if (obs() !== 7'b11_0_0_00_0) begin
            n_err++; $display("FAIL reset_meio: got %b, need %b", obs(), 7'b11_0_0_00_0);
        end
        @(posedge clk);
        @(negedge clk);
        #1;
        n_cmp++;
        if (obs() !== 7'b11_0_0_00_0) begin
            n_err++; $display("FAIL reset_meio_mantido: got %b, need %b", obs(), 7'b11_0_0_00_0);
        end
        rst_n = 1'b1;
    endtask

`ifdef CONTROLE_MUX_VAI_VEM_EN
    task automatic test_vai_vem();
        aplica(1'b0, 1'b1, 1'b0, 1'b0);
        avanca();
        for (int k = 0; k <= 24; k++) begin
            aplica(1'b0, 1'b0, 1'b0, 1'b0);
            n_cmp++;
            if (obs() !== esperado()) begin n_err++; $display("FAIL vai_vem k=%0d: got %b, need %b", k, obs(), esperado()); end
            if (k == 24) begin
                n_cmp++;
                if ({ch1, ch0, ocupado, passo, fim} !== 6'b01_1_00_1) begin
                    n_err++; $display("FAIL vai_vem_volta: got %b, need %b", {ch1, ch0, ocupado, passo, fim}, 6'b01_1_00_1);
                end
            end
            avanca();
        end
        aplica(1'b0, 1'b0, 1'b0, 1'b1);
        avanca();
    endtask
`endif

    task automatic test_aleatorio();
        for (int i = 0; i < 600; i++) begin
            aplica($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                   $urandom_range(0, 7) == 0, $urandom_range(0, 19) == 0);
            n_cmp++;
            if (obs() !== esperado()) begin n_err++; $display("FAIL aleatorio i=%0d: got %b, need %b", i, obs(), esperado()); end
            avanca();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        carregar = 1'b0; iniciar_esq_dir = 1'b0; iniciar_dir_esq = 1'b0; parar = 1'b0;
        modelo_reset();
        repeat (2) @(negedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        test_carga();
        test_esq_dir();
        test_aborto();
        test_troca();
        test_reset_meio();
`ifdef CONTROLE_MUX_VAI_VEM_EN
        test_vai_vem();
`endif
        test_aleatorio();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
